branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the NaiveMIPS front end. In IF it looks up the fetch PC in a direct-mapped table of tagged entries, each holding a 2-bit counter and a branch target, and returns a predicted next PC. In ID the branch resolver supplies `branch`/`branch_addr`, which are fed back here as a training update. The predictor adds history and state that pure combinational resolution in ID lacks.

## Interface
- `ENTRIES`, 64: table depth; power of two, at least 4; `IDX_W = log2(ENTRIES)`.
- `TAG_W`, 8: tag width; `IDX_W + TAG_W + 2 <= 32`.
- `GHR_W`, 6: global history width; `GHR_W <= IDX_W`. Used only when `BP_GSHARE_EN` is defined.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `lookup_pc` in `W_ADDR`: fetch PC in IF.
- `pred_taken` out 1: predicted taken.
- `pred_addr` out `W_ADDR`: predicted next PC.
- `pred_idx` out `IDX_W`: table index used for this lookup; the pipeline carries it to ID.
- `upd_en` in 1: a resolved conditional branch or jump is in ID this cycle.
- `upd_pc` in `W_ADDR`: PC of the resolved instruction.
- `upd_idx` in `IDX_W`: the `pred_idx` carried with that instruction.
- `upd_taken` in 1: the resolver's `branch` output.
- `upd_addr` in `W_ADDR`: the resolver's `branch_addr` output.

## Operation
- Per entry: `valid`, `tag[TAG_W]`, `ctr[2]`, `target[32]`. Global history register `ghr[GHR_W]`.
- Index: `pc[IDX_W+1:2]`. With gshare, XOR it with the zero-extended `ghr`.
- Tag: `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- Lookup (combinational):
  - `hit = valid[idx] & (tag[idx] == lookup tag)`.
  - `pred_taken = hit & ctr[idx][1]`.
  - `pred_addr = pred_taken ? target[idx] : lookup_pc + 4`, with 32-bit wrap-around.
- Update on a rising edge with `upd_en=1`, at entry `upd_idx`, matching against the tag of `upd_pc`:
  - Tag hit, taken: `ctr` saturating increment (max 11); `target <= upd_addr`.
  - Tag hit, not taken: `ctr` saturating decrement (min 00); `target` unchanged.
  - Miss, taken: allocate or replace the entry. `valid <= 1`, new tag, `target <= upd_addr`, `ctr <= 10`.
  - Miss, not taken: no table change.
  - With gshare: `ghr <= {ghr[GHR_W-2:0], upd_taken}` on every update.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Correcting a mispredict is the pipeline's job. This block only predicts and trains.

## Timing
- Lookup: zero latency, combinational from `lookup_pc` and the registered table/`ghr`.
- Update: visible to lookups from the next cycle.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update contents. There is no bypass.
- `upd_en` is ignored when low. Back-to-back updates are legal every cycle.
- Reset, asserted at any time including mid-update: immediately clears every `valid` to 0, every `ctr` to 01, and `ghr` to 0. `target`/`tag` need not be reset.
- Outputs under reset: `pred_taken=0`, `pred_addr=lookup_pc+4`, `pred_idx` = the index computed from `lookup_pc` with `ghr=0`.

## Configuration
- `BP_GSHARE_EN` defined: gshare indexing (PC XOR `ghr`), and `ghr` is instantiated and updated.
- `BP_GSHARE_EN` undefined: bimodal indexing from PC bits only. No `ghr` register; `GHR_W` is unused.

## Structure
- Shared package / `defines.vh`:
  - `W_ADDR`
  - counter encodings `BP_SNT/BP_WNT/BP_WT/BP_ST`
  - allocation value `BP_CTR_INIT = BP_WT`
  - reset value `BP_CTR_RST = BP_WNT`
- Sub-module `bp_counter`: 2-bit saturating next-state logic (`ctr`, `taken` -> `ctr_next`), instantiated once on the update path.
- The table is flop arrays, not block RAM, because lookup is asynchronous.

## Test plan
All cases use ENTRIES=64, TAG_W=8, and gshare off unless noted.
- **After reset:** `lookup_pc=0x00400000` -> `pred_taken=0`, `pred_addr=0x00400004`, `pred_idx=0`.
- **Allocate on taken:** update `upd_pc=0x00400010`, `upd_idx=4`, taken, `upd_addr=0x00400100`. Next cycle, lookup `0x00400010` -> `pred_taken=1`, `pred_addr=0x00400100`, ctr=10.
- **Train down / saturate up:** two not-taken updates -> ctr 01 then 00, prediction `0x00400014`. Then five taken updates -> ctr 11; one not-taken -> 10, still predicts taken.
- **Alias replacement:** lookup `0x00401010` (idx 4, tag 0x10) -> miss, not taken. A taken update to `0x00401200` replaces the entry; `0x00400010` then misses.
- **Same-cycle hazard and reset:** same-cycle update and lookup at idx 4 -> lookup returns old contents. Asserting `rst` mid-sequence -> `pred_taken=0` in the same cycle.
- **Gshare (`BP_GSHARE_EN`):** one taken update gives `ghr=000001`. Lookup `0x00400010` -> `pred_idx=5`.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the NaiveMIPS branch predictor: address width and
// 2-bit counter encodings.
package branch_predictor_pkg;

  localparam int W_ADDR = 32;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  // Fresh allocations start weakly taken; reset leaves every counter weakly not-taken.
  localparam bp_ctr_e BP_CTR_INIT = BP_WT;
  localparam bp_ctr_e BP_CTR_RST  = BP_WNT;

endpackage

// File: rtl/bp_counter.sv
// 2-bit saturating counter next-state logic used on the predictor update path.
module bp_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch predictor: combinational lookup in IF, training from ID.
// Define BP_GSHARE_EN to XOR the index with a global history register (gshare).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W_ADDR-1:0]          lookup_pc,
  output logic                       pred_taken,
  output logic [W_ADDR-1:0]          pred_addr,
  output logic [$clog2(ENTRIES)-1:0] pred_idx,
  input  logic                       upd_en,
  input  logic [W_ADDR-1:0]          upd_pc,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx,
  input  logic                       upd_taken,
  input  logic [W_ADDR-1:0]          upd_addr
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;

  // Flop arrays rather than block RAM: the lookup is read asynchronously.
  logic              valid_reg  [ENTRIES];
  logic [1:0]        ctr_reg    [ENTRIES];
  logic [TAG_W-1:0]  tag_reg    [ENTRIES];
  logic [W_ADDR-1:0] target_reg [ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             lookup_hit;
  logic             upd_hit;
  logic [1:0]       ctr_next;
  logic             unused_bits;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (upd_en) begin
      ghr_reg <= {ghr_reg[GHR_W-2:0], upd_taken};
    end
  end

  assign lookup_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_reg);
`else
  localparam int GHR_W_UNUSED = GHR_W;

  assign lookup_idx = lookup_pc[IDX_W+1:2];
`endif

  assign lookup_tag = lookup_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign upd_tag    = upd_pc[TAG_LO+TAG_W-1:TAG_LO];

  assign lookup_hit = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == lookup_tag);
  assign pred_taken = lookup_hit && ctr_reg[lookup_idx][1];
  assign pred_addr  = pred_taken ? target_reg[lookup_idx] : lookup_pc + 32'd4;
  assign pred_idx   = lookup_idx;

  // The update index comes from the pipeline, so it already includes any history hashing.
  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

  // PC bits outside the index/tag fields never affect the table.
  assign unused_bits = ^upd_pc;

  bp_counter u_counter (
    .ctr      (ctr_reg[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= BP_CTR_RST;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_reg[upd_idx] <= ctr_next;
      end else if (upd_taken) begin
        valid_reg[upd_idx] <= 1'b1;
        ctr_reg[upd_idx]   <= BP_CTR_INIT;
      end
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_reg[upd_idx]    <= upd_tag;
      target_reg[upd_idx] <= upd_addr;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic checked against a behavioural table model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int GHR_W   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic [5:0]  pred_idx;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [5:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_addr = '0;

  int checks = 0;
  int passes = 0;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .GHR_W(GHR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (lookup_pc),
    .pred_taken (pred_taken),
    .pred_addr  (pred_addr),
    .pred_idx   (pred_idx),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken),
    .upd_addr   (upd_addr)
  );

  always #5 clk = ~clk;

  // Behavioural model: counters as integers 0..3, tag/index by division.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int unsigned m_ghr;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  function automatic int unsigned m_index(input logic [31:0] pc);
    int unsigned i;
    i = (pc / 4) % ENTRIES;
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input int unsigned idx,
                                   input bit taken, input logic [31:0] addr);
    bit hit;
    hit = m_valid[idx] && (m_tag[idx] == m_tagof(pc));
    if (hit) begin
      if (taken) begin
        m_ctr[idx]    = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_target[idx] = addr;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = m_tagof(pc);
      m_ctr[idx]    = 2;
      m_target[idx] = addr;
    end
`ifdef BP_GSHARE_EN
    m_ghr = (m_ghr * 2 + (taken ? 1 : 0)) % (1 << GHR_W);
`endif
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output logic t,
                                    output logic [31:0] a, output logic [5:0] ix);
    int unsigned i;
    i  = m_index(pc);
    t  = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    a  = t ? m_target[i] : pc + 32'd4;
    ix = 6'(i);
  endfunction

  // Presents an update for one clock edge, then mirrors it in the model.
  task automatic drive_update(input logic [31:0] pc, input logic [5:0] idx,
                              input logic taken, input logic [31:0] addr);
    upd_en = 1'b1; upd_pc = pc; upd_idx = idx; upd_taken = taken; upd_addr = addr;
    @(posedge clk);
    m_update(pc, idx, taken, addr);
    #1;
    upd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [2];
    logic [31:0] exp_a [2];
    logic [5:0]  exp_i [2];
    pcs[0] = 32'h0040_0000; exp_a[0] = 32'h0040_0004; exp_i[0] = 6'd0;
    pcs[1] = 32'hFFFF_FFFC; exp_a[1] = 32'h0000_0000; exp_i[1] = 6'd63;
    lookup_pc = pcs[0];
    #1 rst = 1'b1;
    #2;
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== exp_a[0] || pred_idx !== exp_i[0])
      $display("FAIL reset_async: got taken=%0b addr=%h idx=%0d, expected taken=0 addr=%h idx=%0d",
               pred_taken, pred_addr, pred_idx, exp_a[0], exp_i[0]);
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      lookup_pc = pcs[k];
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_addr !== exp_a[k] || pred_idx !== exp_i[k])
        $display("FAIL reset_state pc=%h: got taken=%0b addr=%h idx=%0d, expected taken=0 addr=%h idx=%0d",
                 pcs[k], pred_taken, pred_addr, pred_idx, exp_a[k], exp_i[k]);
      else passes++;
    end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_allocate();
    logic et; logic [31:0] ea; logic [5:0] ei;
    drive_update(32'h0040_0010, 6'd4, 1'b1, 32'h0040_0100);
    lookup_pc = 32'h0040_0010;
    #1;
    m_predict(lookup_pc, et, ea, ei);
    checks++;
    if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
      $display("FAIL allocate: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
               pred_taken, pred_addr, pred_idx, et, ea, ei);
    else passes++;
  endtask

  task automatic test_train();
    logic et; logic [31:0] ea; logic [5:0] ei;
    logic dirs [8];
    dirs[0] = 1'b0; dirs[1] = 1'b0;
    for (int k = 2; k < 7; k++) dirs[k] = 1'b1;
    dirs[7] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_update(32'h0040_0010, 6'd4, dirs[k], 32'h0040_0100);
      lookup_pc = 32'h0040_0010;
      #1;
      m_predict(lookup_pc, et, ea, ei);
      checks++;
      if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
        $display("FAIL train step %0d: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
                 k, pred_taken, pred_addr, pred_idx, et, ea, ei);
      else passes++;
    end
  endtask

  task automatic test_alias();
    logic et; logic [31:0] ea; logic [5:0] ei;
    logic [31:0] pcs [3];
    pcs[0] = 32'h0040_1010; pcs[1] = 32'h0040_1010; pcs[2] = 32'h0040_0010;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) drive_update(32'h0040_1010, 6'd4, 1'b1, 32'h0040_1200);
      lookup_pc = pcs[k];
      #1;
      m_predict(lookup_pc, et, ea, ei);
      checks++;
      if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
        $display("FAIL alias step %0d: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
                 k, pred_taken, pred_addr, pred_idx, et, ea, ei);
      else passes++;
    end
  endtask

  task automatic test_same_cycle();
    logic et; logic [31:0] ea; logic [5:0] ei;
    lookup_pc = 32'h0040_1010;
    upd_en = 1'b1; upd_pc = 32'h0040_1010; upd_idx = 6'd4; upd_taken = 1'b0;
    upd_addr = 32'h0000_0000;
    #2;
    m_predict(lookup_pc, et, ea, ei);
    checks++;
    if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
      $display("FAIL same_cycle_pre: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
               pred_taken, pred_addr, pred_idx, et, ea, ei);
    else passes++;
    @(posedge clk);
    m_update(upd_pc, upd_idx, upd_taken, upd_addr);
    #1 upd_en = 1'b0;
    #1;
    m_predict(lookup_pc, et, ea, ei);
    checks++;
    if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
      $display("FAIL same_cycle_post: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
               pred_taken, pred_addr, pred_idx, et, ea, ei);
    else passes++;
  endtask

  task automatic test_reset_mid_update();
    logic et; logic [31:0] ea; logic [5:0] ei;
    drive_update(32'h0040_1010, 6'd4, 1'b1, 32'h0040_1200);
    drive_update(32'h0040_1010, 6'd4, 1'b1, 32'h0040_1200);
    lookup_pc = 32'h0040_1010;
    upd_en = 1'b1; upd_pc = 32'h0040_2020; upd_idx = 6'd8; upd_taken = 1'b1;
    upd_addr = 32'h0040_3000;
    #1;
    m_predict(lookup_pc, et, ea, ei);
    checks++;
    if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
      $display("FAIL pre_reset: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
               pred_taken, pred_addr, pred_idx, et, ea, ei);
    else passes++;
    #2 rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== 32'h0040_1014 || pred_idx !== 6'(m_index(lookup_pc)))
      $display("FAIL reset_mid_cycle: got taken=%0b addr=%h idx=%0d, expected taken=0 addr=00401014 idx=%0d",
               pred_taken, pred_addr, pred_idx, m_index(lookup_pc));
    else passes++;
    @(posedge clk);
    #1 upd_en = 1'b0;
    #2 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lookup_pc = (k == 0) ? 32'h0040_1010 : 32'h0040_2020;
      #1;
      m_predict(lookup_pc, et, ea, ei);
      checks++;
      if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
        $display("FAIL post_reset pc=%h: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
                 lookup_pc, pred_taken, pred_addr, pred_idx, et, ea, ei);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic et; logic [31:0] ea; logic [5:0] ei;
    logic [31:0] pc;
    for (int k = 0; k < 6; k++) begin
      pc = 32'h0040_0500 + 32'(k * 4);
      drive_update(pc, 6'(m_index(pc)), 1'b1, 32'h0050_0000 + 32'(k * 16));
    end
    for (int k = 0; k < 6; k++) begin
      lookup_pc = 32'h0040_0500 + 32'(k * 4);
      #1;
      m_predict(lookup_pc, et, ea, ei);
      checks++;
      if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
        $display("FAIL back_to_back %0d: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
                 k, pred_taken, pred_addr, pred_idx, et, ea, ei);
      else passes++;
    end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return 32'h0040_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic test_random();
    logic et; logic [31:0] ea; logic [5:0] ei;
    for (int k = 0; k < 300; k++) begin
      lookup_pc = rand_pc();
      upd_en    = ($urandom_range(0, 3) != 0);
      upd_pc    = rand_pc();
      upd_idx   = 6'(m_index(upd_pc));
      upd_taken = ($urandom_range(0, 9) < 6);
      upd_addr  = $urandom & 32'hFFFF_FFFC;
      #2;
      m_predict(lookup_pc, et, ea, ei);
      checks++;
      if (pred_taken !== et || pred_addr !== ea || pred_idx !== ei)
        $display("FAIL random %0d pc=%h: got taken=%0b addr=%h idx=%0d, expected taken=%0b addr=%h idx=%0d",
                 k, lookup_pc, pred_taken, pred_addr, pred_idx, et, ea, ei);
      else passes++;
      @(posedge clk);
      if (upd_en) m_update(upd_pc, upd_idx, upd_taken, upd_addr);
      #1;
    end
    upd_en = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    @(posedge clk);
    #1;
    test_allocate();
    test_train();
    test_alias();
    test_same_cycle();
    test_reset_mid_update();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
